ladybird_inst_prefetch: RTL

//  Instruction prefetch buffer between the core's instruction port and the instruction memory bus.

---
 rtl/ladybird_inst_prefetch_pkg.sv | 14 +
 rtl/ladybird_inst_prefetch_if.sv | 13 +
 rtl/ladybird_inst_prefetch_fifo.sv | 45 ++++
 rtl/ladybird_inst_prefetch.sv | 136 +++++++++++++
 4 files changed

// File: rtl/ladybird_inst_prefetch_pkg.sv
// Shared configuration for the ladybird instruction prefetcher:
// word width, default buffer depth, instruction word type and alignment.
package ladybird_inst_prefetch_pkg;
    localparam int XLEN           = 32;
    localparam int PREFETCH_DEPTH = 4;
    localparam logic [1:0] INST_ALIGN = 2'b00;

    typedef logic [XLEN-1:0] inst_t;

    // Sequential word address; wraps modulo 2^XLEN.
    function automatic inst_t next_word(input inst_t a);
        return a + inst_t'(4);
    endfunction
endpackage

// File: rtl/ladybird_inst_prefetch_if.sv
// Request/grant/response port shared by the core side and the memory side.
// master drives req/addr, slave returns gnt/data_gnt/data.
interface ladybird_inst_prefetch_if;
    import ladybird_inst_prefetch_pkg::*;
    logic  req;
    inst_t addr;
    logic  gnt;
    logic  data_gnt;
    inst_t data;

    modport master (output req, addr, input gnt, data_gnt, data);
    modport slave  (input req, addr, output gnt, data_gnt, data);
endinterface

// File: rtl/ladybird_inst_prefetch_fifo.sv
// DEPTH x XLEN synchronous FIFO holding prefetched words in address order.
// Clear wins over push/pop; push and pop together leave the count unchanged.
module ladybird_prefetch_fifo
    import ladybird_inst_prefetch_pkg::*;
#(
    parameter int DEPTH = PREFETCH_DEPTH,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          anrst,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic          i_clear,
    input  inst_t         i_wdata,
    output inst_t         o_rdata,
    output logic [CW-1:0] o_count
);
    logic [AW-1:0] r_rd, r_wr;
    logic [CW-1:0] r_cnt;
    inst_t         r_mem [DEPTH];

    // Storage needs no reset: entries are only read while counted valid.
    always_ff @(posedge clk)
        if (i_push && !i_clear) r_mem[r_wr] <= i_wdata;

    // Pointers and occupancy.
    always_ff @(posedge clk or negedge anrst)
        if (!anrst) begin
            r_rd  <= '0;
            r_wr  <= '0;
            r_cnt <= '0;
        end else if (i_clear) begin
            r_rd  <= '0;
            r_wr  <= '0;
            r_cnt <= '0;
        end else begin
            if (i_push) r_wr <= r_wr + 1'b1;
            if (i_pop)  r_rd <= r_rd + 1'b1;
            r_cnt <= r_cnt + CW'(i_push) - CW'(i_pop);
        end

    assign o_rdata = r_mem[r_rd];
    assign o_count = r_cnt;
endmodule

// File: rtl/ladybird_inst_prefetch.sv
// Instruction prefetch buffer: streams sequential words ahead of the core PC,
// serves in-order hits with a 1-cycle gnt->data_gnt turnaround and restarts
// streaming on a redirect or flush, discarding buffered and in-flight words.
// Optional: define LADYBIRD_PREFETCH_STATS_EN to add o_hit_cnt/o_miss_cnt.
module ladybird_inst_prefetch
    import ladybird_inst_prefetch_pkg::*;
#(
    parameter int    DEPTH      = PREFETCH_DEPTH,
    parameter inst_t RESET_ADDR = '0
) (
    input  logic clk,
    input  logic anrst,
    input  logic nrst,
    input  logic i_flush,
    ladybird_inst_prefetch_if.slave  core,
    ladybird_inst_prefetch_if.master mem
`ifdef LADYBIRD_PREFETCH_STATS_EN
    ,
    output logic [31:0] o_hit_cnt,
    output logic [31:0] o_miss_cnt
`endif
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = CW + 1;   // headroom for count+inflight+1

    logic [CW-1:0] w_count, r_inflight, r_drop, w_inflight_nxt;
    inst_t         r_head, r_fetch, r_maddr, r_data, w_rdata, w_target, w_fetch_nxt;
    logic          r_mreq, r_stale, r_dgnt;
    logic          w_hit, w_gnt, w_redir, w_restart, w_acc, w_resp, w_dropping, w_push, w_issue;
    logic [SW-1:0] w_live, w_total;

    // Core side: a hit pops the head; any other address restarts the stream.
    assign w_hit     = core.req && (w_count != '0) && (core.addr == r_head);
    assign w_gnt     = nrst && w_hit && !r_dgnt && !i_flush;
    assign w_redir   = nrst && core.req && (core.addr != r_head);
    assign w_restart = w_redir || (nrst && i_flush);
    assign w_target  = w_redir ? {core.addr[XLEN-1:2], INST_ALIGN} : r_head;

    // Bus side: responses owed to stale requests are swallowed via r_drop.
    assign w_acc          = r_mreq && mem.gnt;
    assign w_resp         = mem.data_gnt;
    assign w_dropping     = w_resp && (r_drop != '0);
    assign w_push         = w_resp && (r_drop == '0) && !w_restart;
    assign w_inflight_nxt = r_inflight + CW'(w_acc) - CW'(w_resp);
    assign w_fetch_nxt    = w_restart ? w_target : (w_acc ? next_word(r_fetch) : r_fetch);

    // Reserve a buffer slot for every live request so a push never overflows,
    // and never exceed DEPTH outstanding bus requests in total.
    assign w_live  = SW'(w_count) + SW'(r_inflight) - SW'(r_drop) + SW'(w_acc && !r_stale);
    assign w_total = SW'(r_inflight) + SW'(w_acc);
    assign w_issue = !w_restart && (w_live < SW'(DEPTH)) && (w_total < SW'(DEPTH));

    ladybird_prefetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .anrst   (anrst),
        .i_push  (w_push),
        .i_pop   (w_gnt),
        .i_clear (w_restart || !nrst),
        .i_wdata (mem.data),
        .o_rdata (w_rdata),
        .o_count (w_count)
    );

    // Stream pointers, outstanding/drop accounting and the bus request register.
    always_ff @(posedge clk or negedge anrst)
        if (!anrst) begin
            r_inflight <= '0;
            r_drop     <= '0;
            r_head     <= RESET_ADDR;
            r_fetch    <= RESET_ADDR;
            r_mreq     <= 1'b0;
            r_stale    <= 1'b0;
            r_maddr    <= RESET_ADDR;
        end else if (!nrst) begin
            r_inflight <= '0;
            r_drop     <= '0;
            r_head     <= RESET_ADDR;
            r_fetch    <= RESET_ADDR;
            r_mreq     <= 1'b0;
            r_stale    <= 1'b0;
            r_maddr    <= RESET_ADDR;
        end else begin
            r_inflight <= w_inflight_nxt;
            r_drop     <= w_restart ? w_inflight_nxt
                                    : r_drop - CW'(w_dropping) + CW'(w_acc && r_stale);
            r_head     <= w_restart ? w_target : (w_gnt ? next_word(r_head) : r_head);
            r_fetch    <= w_fetch_nxt;
            if (w_acc || !r_mreq) begin
                r_mreq  <= w_issue;
                r_stale <= 1'b0;
                if (w_issue) r_maddr <= w_fetch_nxt;
            end else if (w_restart) begin
                // pending request is held unchanged; its word gets dropped
                r_stale <= 1'b1;
            end
        end

    // Registered core response: one-cycle data_gnt pulse with the popped word.
    always_ff @(posedge clk or negedge anrst)
        if (!anrst) begin
            r_dgnt <= 1'b0;
            r_data <= '0;
        end else if (!nrst) begin
            r_dgnt <= 1'b0;
            r_data <= '0;
        end else begin
            r_dgnt <= w_gnt;
            if (w_gnt) r_data <= w_rdata;
        end

    assign core.gnt      = w_gnt;
    assign core.data_gnt = r_dgnt;
    assign core.data     = r_data;
    assign mem.req       = r_mreq;
    assign mem.addr      = r_maddr;

`ifdef LADYBIRD_PREFETCH_STATS_EN
    logic [31:0] r_hit_cnt, r_miss_cnt;

    // Hit/miss event counters, wrapping.
    always_ff @(posedge clk or negedge anrst)
        if (!anrst) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (!nrst) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            r_hit_cnt  <= r_hit_cnt + 32'(w_gnt);
            r_miss_cnt <= r_miss_cnt + 32'(w_redir);
        end

    assign o_hit_cnt  = r_hit_cnt;
    assign o_miss_cnt = r_miss_cnt;
`endif
endmodule
